// File: rtl/jt12_slot_seq_if.sv
// jt12_slot_seq_if: register-write request bus into the slot sequencer
interface jt12_slot_seq_if;
  logic       wr_req;
  logic [2:0] wr_ch;
  logic [1:0] wr_op;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       wr_err;
  modport master(output wr_req, wr_ch, wr_op, wr_data, input wr_ack, wr_err);
  modport slave(input wr_req, wr_ch, wr_op, wr_data, output wr_ack, wr_err);
endinterface

// File: rtl/jt12_slot_seq.sv
// jt12_slot_seq: 24-slot YM2612 channel/operator sequencer with a one-entry write buffer
// Define JT12_SEQ_TAPS_EN to build the ch_ii/ch_iii delay taps.
module jt12_slot_seq (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clk_en_i,
  jt12_slot_seq_if.slave  wr,
  output logic [4:0]      cur_ch_o,
  output logic [4:0]      slot_o,
  output logic            zero_o,
  output logic            upd_en_o,
  output logic [7:0]      upd_data_o,
  output logic [4:0]      ch_ii_o,
  output logic [4:0]      ch_iii_o
);
  logic [4:0] cur_ch_q, cur_ch_d, slot_q, slot_d, buf_code_q;
  logic [7:0] buf_data_q, upd_data_q;
  logic       buf_v_q, ack_q, err_q, upd_q;
  logic [2:0] low_inc, low;
  logic       accept, drain, bad_ch;
  assign low_inc = cur_ch_q[2:0] + 3'd1;
  assign low     = low_inc + {2'b0, &low_inc[1:0]};
  always_comb begin
    cur_ch_d = clk_en_i ? {cur_ch_q[4:3] + {1'b0, cur_ch_q[2:0] == 3'd6}, low} : cur_ch_q;
    slot_d   = clk_en_i ? (slot_q == 5'd23 ? 5'd0 : slot_q + 5'd1) : slot_q;
  end
  // Drain is decided against the next slot so upd_en lines up with its slot code.
  assign accept = wr.wr_req && !buf_v_q;
  assign bad_ch = &wr.wr_ch[1:0];
  assign drain  = buf_v_q && clk_en_i && cur_ch_d == buf_code_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch_q   <= 5'd0;
      slot_q     <= 5'd0;
      buf_v_q    <= 1'b0;
      buf_code_q <= 5'd0;
      buf_data_q <= 8'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      upd_q      <= 1'b0;
      upd_data_q <= 8'd0;
    end else begin
      cur_ch_q <= cur_ch_d;
      slot_q   <= slot_d;
      ack_q    <= accept;
      err_q    <= accept && bad_ch;
      upd_q    <= drain;
      if (drain) begin
        buf_v_q    <= 1'b0;
        upd_data_q <= buf_data_q;
      end else if (accept && !bad_ch) begin
        buf_v_q    <= 1'b1;
        buf_code_q <= {wr.wr_op, wr.wr_ch};
        buf_data_q <= wr.wr_data;
      end
    end
  end
  assign cur_ch_o   = cur_ch_q;
  assign slot_o     = slot_q;
  assign zero_o     = cur_ch_q == 5'd0;
  assign upd_en_o   = upd_q;
  assign upd_data_o = upd_data_q;
  assign wr.wr_ack  = ack_q;
  assign wr.wr_err  = err_q;
`ifdef JT12_SEQ_TAPS_EN
  logic [4:0] ch_ii_q, ch_iii_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_ii_q  <= 5'd0;
      ch_iii_q <= 5'd0;
    end else if (clk_en_i) begin
      ch_ii_q  <= cur_ch_q;
      ch_iii_q <= ch_ii_q;
    end
  end
  assign ch_ii_o  = ch_ii_q;
  assign ch_iii_o = ch_iii_q;
`else
  assign ch_ii_o  = 5'd0;
  assign ch_iii_o = 5'd0;
`endif
endmodule
